decode_sequencer: RTL

- Front-end controller for the combinational instruction decoder.
- Owns the three-deep instruction history (COMMAND, BeforeCOMMAND, TwoBeforeCOMMAND) that the decoder consumes, and sequences it.
- Handles load-use stalls, branch flushes, IN/OUT handshakes with the I/O port, and HLT/resume.
- Drives fetch advance (pc_enable) toward the PC and fetch stage.

---
 rtl/simple_isa_pkg.sv | 31 +++
 rtl/hazard_detect.sv | 39 +++
 rtl/decode_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/simple_isa_pkg.sv
// Shared ISA constants, sequencer state encoding and the per-cycle history action.
package simple_isa_pkg;

  localparam logic [1:0] OP_ARITH = 2'b11;
  localparam logic [1:0] OP_LD    = 2'b00;
  localparam logic [1:0] OP_ST    = 2'b01;
  localparam logic [1:0] OP_IMM   = 2'b10;

  localparam logic [3:0] OP3_IN  = 4'b1100;
  localparam logic [3:0] OP3_OUT = 4'b1101;
  localparam logic [3:0] OP3_HLT = 4'b1111;

  localparam logic [15:0] BUBBLE = 16'hC0E0;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_STALL    = 3'd1,
    ST_WAIT_IN  = 3'd2,
    ST_WAIT_OUT = 3'd3,
    ST_HALT     = 3'd4
  } seq_state_e;

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_ADVANCE,
    ACT_INSERT,
    ACT_FLUSH,
    ACT_RESUME
  } hist_act_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard: BeforeCOMMAND is a load whose destination COMMAND reads.
module hazard_detect
  import simple_isa_pkg::*;
(
  input  logic [15:0] COMMAND,
  input  logic [15:0] BeforeCOMMAND,
  output logic        load_use
);

  logic [3:0] w_op3;
  logic       w_reads_a;
  logic       w_reads_b;
  logic       w_unused_bits;

  assign w_op3         = COMMAND[7:4];
  assign w_unused_bits = ^{COMMAND[3:0], BeforeCOMMAND[10:0]};

  always_comb begin
    w_reads_a = 1'b0;
    w_reads_b = 1'b0;
    unique case (COMMAND[15:14])
      OP_ARITH: begin
        w_reads_a = (w_op3 <= 4'd6) || (w_op3 == OP3_OUT);
        w_reads_b = (w_op3 <= 4'd5) || ((w_op3 >= 4'd8) && (w_op3 <= 4'd11));
      end
      OP_LD: w_reads_a = 1'b1;
      OP_ST: begin
        w_reads_a = 1'b1;
        w_reads_b = 1'b1;
      end
      OP_IMM: ;
    endcase
  end

  assign load_use = (BeforeCOMMAND[15:14] == OP_LD) &&
                    ((w_reads_a && (COMMAND[10:8]  == BeforeCOMMAND[13:11])) ||
                     (w_reads_b && (COMMAND[13:11] == BeforeCOMMAND[13:11])));

endmodule

// File: rtl/decode_sequencer.sv
// Decode front-end sequencer: owns the three-deep instruction history and
// arbitrates flush, halt, load-use stall, IN/OUT handshake and normal advance.
module decode_sequencer
  import simple_isa_pkg::*;
#(
  parameter int LD_STALL_CYCLES = 1,
  parameter int HALT_ON_HLT     = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        fetch_valid,
  input  logic [15:0] FETCH_COMMAND,
  input  logic        branch_taken,
  input  logic        in_valid,
  input  logic        out_ready,
  input  logic        resume,
  output logic [15:0] COMMAND,
  output logic [15:0] BeforeCOMMAND,
  output logic [15:0] TwoBeforeCOMMAND,
  output logic        pc_enable,
  output logic        issue_valid,
  output logic        flush,
  output logic        in_ack,
  output logic        out_strobe,
  output logic        halted,
  output logic [2:0]  state
);

  localparam logic [1:0] STALL_INIT = 2'(LD_STALL_CYCLES - 1);
  localparam logic       HALT_EN    = (HALT_ON_HLT != 0);

  seq_state_e  r_state;
  seq_state_e  w_nstate;
  hist_act_e   w_act;
  logic [15:0] r_cmd, r_bcmd, r_tbcmd;
  logic [1:0]  r_cnt, w_ncnt;
  logic        w_load_use, w_arith, w_is_in, w_is_out, w_is_hlt;
  logic        w_pc_en, w_issue, w_flush, w_in_ack, w_out_strobe;

  hazard_detect u_hazard (
    .COMMAND       (r_cmd),
    .BeforeCOMMAND (r_bcmd),
    .load_use      (w_load_use)
  );

  assign w_arith  = (r_cmd[15:14] == OP_ARITH);
  assign w_is_in  = w_arith && (r_cmd[7:4] == OP3_IN);
  assign w_is_out = w_arith && (r_cmd[7:4] == OP3_OUT);
  assign w_is_hlt = w_arith && (r_cmd[7:4] == OP3_HLT);

  always_comb begin
    w_act        = ACT_HOLD;
    w_nstate     = r_state;
    w_ncnt       = r_cnt;
    w_pc_en      = 1'b0;
    w_issue      = 1'b0;
    w_flush      = 1'b0;
    w_in_ack     = 1'b0;
    w_out_strobe = 1'b0;
    // A taken branch abandons any stall count or pending handshake.
    if (branch_taken && (r_state != ST_HALT)) begin
      w_act    = ACT_FLUSH;
      w_nstate = ST_RUN;
      w_ncnt   = 2'd0;
      w_pc_en  = 1'b1;
      w_flush  = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_is_hlt && HALT_EN) begin
            w_nstate = ST_HALT;
          end else if (w_load_use) begin
            w_act    = ACT_INSERT;
            w_ncnt   = STALL_INIT;
            w_nstate = (STALL_INIT != 2'd0) ? ST_STALL : ST_RUN;
          end else if (w_is_in && !in_valid) begin
            w_nstate = ST_WAIT_IN;
          end else if (w_is_out && !out_ready) begin
            w_nstate = ST_WAIT_OUT;
          end else begin
            w_act        = ACT_ADVANCE;
            w_pc_en      = 1'b1;
            w_issue      = 1'b1;
            w_in_ack     = w_is_in;
            w_out_strobe = w_is_out;
          end
        end
        ST_STALL: begin
          w_act  = ACT_INSERT;
          w_ncnt = r_cnt - 2'd1;
          if (r_cnt <= 2'd1) w_nstate = ST_RUN;
        end
        ST_WAIT_IN: begin
          if (in_valid) begin
            w_act    = ACT_ADVANCE;
            w_pc_en  = 1'b1;
            w_issue  = 1'b1;
            w_in_ack = 1'b1;
            w_nstate = ST_RUN;
          end
        end
        ST_WAIT_OUT: begin
          if (out_ready) begin
            w_act        = ACT_ADVANCE;
            w_pc_en      = 1'b1;
            w_issue      = 1'b1;
            w_out_strobe = 1'b1;
            w_nstate     = ST_RUN;
          end
        end
        ST_HALT: begin
          if (resume) begin
            w_act    = ACT_RESUME;
            w_issue  = 1'b1;
            w_nstate = ST_RUN;
          end
        end
        default: w_nstate = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd   <= BUBBLE;
      r_bcmd  <= BUBBLE;
      r_tbcmd <= BUBBLE;
      r_state <= ST_RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      case (w_act)
        ACT_ADVANCE: begin
          r_tbcmd <= r_bcmd;
          r_bcmd  <= r_cmd;
          r_cmd   <= fetch_valid ? FETCH_COMMAND : BUBBLE;
        end
        ACT_INSERT: begin
          r_tbcmd <= r_bcmd;
          r_bcmd  <= BUBBLE;
        end
        ACT_FLUSH: r_cmd <= BUBBLE;
        ACT_RESUME: begin
          r_tbcmd <= r_bcmd;
          r_bcmd  <= r_cmd;
          r_cmd   <= BUBBLE;
        end
        default: ;
      endcase
    end
  end

  // Control outputs are decisions for the current cycle; reset silences them.
  assign COMMAND          = r_cmd;
  assign BeforeCOMMAND    = r_bcmd;
  assign TwoBeforeCOMMAND = r_tbcmd;
  assign pc_enable        = reset_n && w_pc_en;
  assign issue_valid      = reset_n && w_issue;
  assign flush            = reset_n && w_flush;
  assign in_ack           = reset_n && w_in_ack;
  assign out_strobe       = reset_n && w_out_strobe;
  assign halted           = (r_state == ST_HALT);
  assign state            = r_state;

endmodule
